// File: rtl/hd44780_reader.sv
// HD44780 read engine: one RS/RW/E read transaction per request.
// Define HD44780_READER_4BIT_EN to build the 4-bit variant (two strobes, DB[7:4] only).
module hd44780_reader #(
   parameter int unsigned SETUP_CYCLES  = 2,
   parameter int unsigned E_HIGH_CYCLES = 25,
   parameter int unsigned E_LOW_CYCLES  = 25
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req,
   input  logic       rs_sel,
   output logic       ready,
   output logic       valid,
   output logic [7:0] rdata,
   output logic       busy,
   output logic       lcd_rs,
   output logic       lcd_rw,
   output logic       lcd_e,
   input  logic [7:0] lcd_db_in
);

   localparam int unsigned MaxSH     = (SETUP_CYCLES > E_HIGH_CYCLES) ? SETUP_CYCLES
                                                                      : E_HIGH_CYCLES;
   localparam int unsigned MaxCycles = (MaxSH > E_LOW_CYCLES) ? MaxSH : E_LOW_CYCLES;
   localparam int unsigned CntW      = $clog2(MaxCycles) + 1;

   typedef enum logic [2:0] {StIdle, StSetup, StEHigh, StELow, StDone} state_e;

   state_e            state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic              rs_q, rs_d;
   logic [7:0]        rdata_q, rdata_d;
   logic              busy_q, busy_d;
   logic              last_nib;

`ifdef HD44780_READER_4BIT_EN
   logic nib_q, nib_d;
   logic unused_db_low;
   assign unused_db_low = ^lcd_db_in[3:0];
   assign last_nib      = nib_q;
`else
   assign last_nib = 1'b1;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rs_d    = rs_q;
      rdata_d = rdata_q;
      busy_d  = busy_q;
`ifdef HD44780_READER_4BIT_EN
      nib_d   = nib_q;
`endif
      ready   = 1'b0;
      valid   = 1'b0;
      lcd_e   = 1'b0;
      lcd_rw  = 1'b0;
      lcd_rs  = 1'b0;
      unique case (state_q)
         StIdle: begin
            ready = 1'b1;
            if (req) begin
               rs_d    = rs_sel;
               cnt_d   = CntW'(SETUP_CYCLES - 1);
               state_d = StSetup;
`ifdef HD44780_READER_4BIT_EN
               nib_d   = 1'b0;
`endif
            end
         end
         StSetup: begin
            lcd_rw = 1'b1;
            lcd_rs = rs_q;
            if (cnt_q == '0) begin
               cnt_d   = CntW'(E_HIGH_CYCLES - 1);
               state_d = StEHigh;
            end else begin
               cnt_d = cnt_q - CntW'(1);
            end
         end
         StEHigh: begin
            lcd_e  = 1'b1;
            lcd_rw = 1'b1;
            lcd_rs = rs_q;
            if (cnt_q == '0) begin
               // Capture on the same edge that drops E.
`ifdef HD44780_READER_4BIT_EN
               if (!nib_q) rdata_d[7:4] = lcd_db_in[7:4];
               else        rdata_d[3:0] = lcd_db_in[7:4];
`else
               rdata_d = lcd_db_in;
`endif
               cnt_d   = CntW'(E_LOW_CYCLES - 1);
               state_d = StELow;
            end else begin
               cnt_d = cnt_q - CntW'(1);
            end
         end
         StELow: begin
            lcd_rw = 1'b1;
            lcd_rs = rs_q;
            if (cnt_q == '0) begin
               if (last_nib) begin
                  // Update busy on entry to DONE so it is valid alongside the pulse.
                  if (!rs_q) busy_d = rdata_q[7];
                  state_d = StDone;
               end else begin
`ifdef HD44780_READER_4BIT_EN
                  nib_d   = 1'b1;
`endif
                  cnt_d   = CntW'(E_HIGH_CYCLES - 1);
                  state_d = StEHigh;
               end
            end else begin
               cnt_d = cnt_q - CntW'(1);
            end
         end
         StDone: begin
            valid   = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         rs_q    <= 1'b0;
         rdata_q <= 8'h00;
         busy_q  <= 1'b0;
`ifdef HD44780_READER_4BIT_EN
         nib_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rs_q    <= rs_d;
         rdata_q <= rdata_d;
         busy_q  <= busy_d;
`ifdef HD44780_READER_4BIT_EN
         nib_q   <= nib_d;
`endif
      end
   end

   assign rdata = rdata_q;
   assign busy  = busy_q;

endmodule

// File: tb/tb_hd44780_reader.sv
// Self-checking bench for hd44780_reader against a cycle-offset model of the read timing.
module tb_hd44780_reader;

   localparam int S  = 2;
   localparam int H  = 25;
   localparam int LO = 25;
`ifdef HD44780_READER_4BIT_EN
   localparam int NIB = 2;
`else
   localparam int NIB = 1;
`endif
   localparam int L = S + NIB * (H + LO);

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req = 1'b0;
   logic       rs_sel = 1'b0;
   logic [7:0] lcd_db_in = 8'h00;
   logic       ready, valid, busy, lcd_rs, lcd_rw, lcd_e;
   logic [7:0] rdata;

   int         vectors = 0;
   int         miscompares = 0;
   logic [7:0] rdata_m = 8'h00;
   logic       busy_m = 1'b0;
   int         cyc = 0;
   int         last_acc = 0;

   hd44780_reader #(
      .SETUP_CYCLES (S),
      .E_HIGH_CYCLES(H),
      .E_LOW_CYCLES (LO)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .rs_sel   (rs_sel),
      .ready    (ready),
      .valid    (valid),
      .rdata    (rdata),
      .busy     (busy),
      .lcd_rs   (lcd_rs),
      .lcd_rw   (lcd_rw),
      .lcd_e    (lcd_e),
      .lcd_db_in(lcd_db_in)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Observed control outputs packed as {ready, valid, e, rw, rs, busy}.
   task automatic check_idle_reset(input string name);
      logic [5:0] got;
      got = {ready, valid, lcd_e, lcd_rw, lcd_rs, busy};
      vectors++;
      if (got !== 6'b100000 || rdata !== 8'h00) begin
         miscompares++;
         $display("FAIL %s: got ctl=%b rdata=%h, want ctl=100000 rdata=00", name, got, rdata);
      end
   endtask

   // One read. cont: req already high from the previous read. hold: keep req high at the end.
   // abort_t >= 0: assert rst at that offset and stop.
   task automatic read_txn(input logic rs, input logic [7:0] b0, input logic [7:0] b1,
                           input bit cont, input bit hold, input int abort_t);
      logic [7:0] exp;
      logic       busy_new;
      logic [5:0] got, want;
      int         n;
      int         pn;
      if (!cont) begin
         @(negedge clk);
         n = 0;
         while (!ready && n < 500) begin
            @(negedge clk);
            n++;
         end
         vectors++;
         if (!ready) begin
            miscompares++;
            $display("FAIL ready_timeout: got ready=%b, want 1", ready);
         end
         req = 1'b1;
      end
      rs_sel    = rs;
      lcd_db_in = 8'($urandom);
      @(posedge clk);
      last_acc = cyc;
      exp      = (NIB == 1) ? b0 : {b0[7:4], b1[7:4]};
      busy_new = rs ? busy_m : exp[7];
      for (int t = 0; t <= L + 1; t++) begin
         @(negedge clk);
         pn = -1;
         for (int p = 0; p < NIB; p++)
            if (t >= S + p * (H + LO) && t < S + p * (H + LO) + H) pn = p;
         got  = {ready, valid, lcd_e, lcd_rw, lcd_rs, busy};
         want = {t == L + 1, t == L, pn >= 0, t < L, (t < L) ? rs : 1'b0,
                 (t >= L) ? busy_new : busy_m};
         vectors++;
         if (got !== want) begin
            miscompares++;
            $display("FAIL ctl t=%0d: got rdy,val,e,rw,rs,busy=%b, want %b", t, got, want);
         end
         if (t >= L) begin
            vectors++;
            if (rdata !== exp) begin
               miscompares++;
               $display("FAIL rdata t=%0d: got %h, want %h", t, rdata, exp);
            end
         end
         if (t == abort_t) begin
            rst = 1'b1;
            req = 1'b0;
            @(negedge clk);
            rst     = 1'b0;
            rdata_m = 8'h00;
            busy_m  = 1'b0;
            check_idle_reset("abort_reset");
            return;
         end
         if (pn == 0)      lcd_db_in = {b0[7:4], (NIB == 1) ? b0[3:0] : 4'($urandom)};
         else if (pn == 1) lcd_db_in = {b1[7:4], 4'($urandom)};
         else              lcd_db_in = 8'($urandom);
         req    = (t < L) ? 1'($urandom_range(0, 1)) : hold;
         rs_sel = 1'($urandom);
      end
      rdata_m = exp;
      busy_m  = busy_new;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1;
      req = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check_idle_reset("reset_hold");
      end
      rst = 1'b0;
      @(negedge clk);
      check_idle_reset("reset_release");
      rdata_m = 8'h00;
      busy_m  = 1'b0;
   endtask

   task automatic test_ir_read();
      read_txn(1'b0, 8'h8A, 8'hA5, 1'b0, 1'b0, -1);
   endtask

   task automatic test_data_read();
      read_txn(1'b1, 8'h41, 8'h1E, 1'b0, 1'b0, -1);
   endtask

   task automatic test_nibbles();
      read_txn(1'b1, 8'h35, 8'hC7, 1'b0, 1'b0, -1);
   endtask

   task automatic test_random();
      for (int i = 0; i < 6; i++)
         read_txn(1'($urandom), 8'($urandom), 8'($urandom), 1'b0, 1'b0, -1);
   endtask

   task automatic test_back_to_back();
      int prev;
      read_txn(1'b0, 8'($urandom), 8'($urandom), 1'b0, 1'b1, -1);
      for (int i = 0; i < 2; i++) begin
         prev = last_acc;
         read_txn(1'($urandom), 8'($urandom), 8'($urandom), 1'b1, i == 0, -1);
         vectors++;
         if (last_acc - prev !== L + 2) begin
            miscompares++;
            $display("FAIL b2b_spacing: got %0d cycles, want %0d", last_acc - prev, L + 2);
         end
      end
   endtask

   task automatic test_reset_mid_strobe();
      read_txn(1'b0, 8'hFF, 8'hF0, 1'b0, 1'b0, S + 9);
      repeat (5) begin
         @(negedge clk);
         vectors++;
         if (valid !== 1'b0 || ready !== 1'b1) begin
            miscompares++;
            $display("FAIL post_abort: got valid=%b ready=%b, want valid=0 ready=1", valid, ready);
         end
      end
      read_txn(1'b0, 8'h8A, 8'hA5, 1'b0, 1'b0, -1);
   endtask

   initial begin
      test_reset();
      test_ir_read();
      test_data_read();
      test_nibbles();
      test_random();
      test_back_to_back();
      test_reset();
      test_reset_mid_strobe();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
